// File: rtl/uart_word_tx_if.sv
// uart_word_tx_if: word handshake from the producer plus the byte-level link to a UART transmitter.
interface uart_word_tx_if #(
  parameter int NBITS  = 8,
  parameter int NBYTES = 4
);
  logic [NBITS*NBYTES-1:0] word_in;
  logic                    word_valid;
  logic                    word_ready;
  logic                    tx_done_tick;
  logic                    tx_start;
  logic [NBITS-1:0]        data_out;
  logic                    busy;
  modport master (output word_in, word_valid, tx_done_tick, input word_ready, tx_start, data_out, busy);
  modport slave (input word_in, word_valid, tx_done_tick, output word_ready, tx_start, data_out, busy);
endinterface

// File: rtl/uart_word_tx.sv
// uart_word_tx: queues words in a FIFO and feeds them to a UART transmitter one byte at a time, LSB first.
module uart_word_tx #(
  parameter int NBITS      = 8,
  parameter int NBYTES     = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic          CLK_100MHZ,
  input  logic          reset,
  uart_word_tx_if.slave bus
);
  localparam int W  = NBITS * NBYTES;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int IW = NBYTES > 1 ? $clog2(NBYTES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);
  localparam logic [PW:0]   FULL = (PW + 1)'(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, START, WAIT} state_t;
  state_t         state_q, state_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic [W-1:0]   sr_q, sr_d;
  logic [PW-1:0]  wp_q, wp_d, rp_q, rp_d;
  logic [PW:0]    cnt_q, cnt_d;
  logic [W-1:0]   mem_q [FIFO_DEPTH];
  logic           push, pop;
  // The word in flight lives only in sr_q, so popping frees its slot at once.
  always_comb begin
    push    = bus.word_valid && cnt_q != FULL;
    pop     = state_q == IDLE && cnt_q != '0;
    state_d = state_q;
    idx_d   = idx_q;
    sr_d    = sr_q;
    case (state_q)
      IDLE: if (pop) begin
        state_d = START;
        idx_d   = '0;
        sr_d    = mem_q[rp_q];
      end
      START: state_d = WAIT;
      default: if (bus.tx_done_tick) begin
        state_d = idx_q == LAST ? IDLE : START;
        idx_d   = idx_q == LAST ? idx_q : idx_q + 1'b1;
        sr_d    = idx_q == LAST ? sr_q : sr_q >> NBITS;
      end
    endcase
    wp_d  = wp_q + PW'(push);
    rp_d  = rp_q + PW'(pop);
    cnt_d = cnt_q + (PW + 1)'(push) - (PW + 1)'(pop);
  end
  always_ff @(posedge CLK_100MHZ or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      sr_q    <= '0;
      wp_q    <= '0;
      rp_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      sr_q    <= sr_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      cnt_q   <= cnt_d;
    end
  end
  always_ff @(posedge CLK_100MHZ) begin
    if (push) mem_q[wp_q] <= bus.word_in;
  end
  assign bus.word_ready = cnt_q != FULL;
  assign bus.tx_start   = state_q == START;
  assign bus.data_out   = sr_q[NBITS-1:0];
  assign bus.busy       = state_q != IDLE || cnt_q != '0;
endmodule

// File: tb/tb_uart_word_tx.sv
// tb_uart_word_tx: directed and randomized checks of uart_word_tx against a byte-stream model.
module tb_uart_word_tx;
  logic CLK_100MHZ = 1'b0;
  logic reset      = 1'b0;
  always #5 CLK_100MHZ = ~CLK_100MHZ;
  uart_word_tx_if #(.NBITS(8), .NBYTES(4)) bus ();
  uart_word_tx #(.NBITS(8), .NBYTES(4), .FIFO_DEPTH(4)) dut (.CLK_100MHZ(CLK_100MHZ), .reset(reset), .bus(bus));
  int nchk = 0;
  int nerr = 0;
  int cyc  = 0;
  logic       man_tick  = 1'b0;
  logic       auto_tick = 1'b0;
  logic       auto_en   = 1'b0;
  logic       rand_dly  = 1'b0;
  int         fixed_dly = 2;
  int         last_push = 0;
  logic [7:0] starts [$];
  logic [7:0] ticks [$];
  logic [7:0] exp_bytes [$];
  int         start_cyc [$];
  int         tick_cyc [$];
  bit         busy_log [0:99999];
  assign bus.tx_done_tick = man_tick | auto_tick;
  always @(posedge CLK_100MHZ) cyc <= cyc + 1;
  always @(negedge CLK_100MHZ) begin
    busy_log[cyc] = bus.busy;
    if (bus.tx_start) begin
      starts.push_back(bus.data_out);
      start_cyc.push_back(cyc);
    end
  end
  // Stand-in UART transmitter: answers each tx_start with a done tick after a delay.
  initial begin
    int d;
    forever begin
      @(negedge CLK_100MHZ);
      auto_tick = 1'b0;
      if (auto_en && bus.tx_start) begin
        d = rand_dly ? int'($urandom_range(1, 6)) : fixed_dly;
        repeat (d) @(negedge CLK_100MHZ);
        tick_cyc.push_back(cyc);
        ticks.push_back(bus.data_out);
        auto_tick = 1'b1;
      end
    end
  end
  initial begin
    #950000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic void add_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) exp_bytes.push_back(8'((w >> (8 * i)) & 32'hFF));
  endfunction
  task automatic clear_logs();
    starts.delete(); ticks.delete(); exp_bytes.delete(); start_cyc.delete(); tick_cyc.delete();
  endtask
  task automatic cmp_stream(input string tag);
    chk({tag, "_count"}, 64'(starts.size()), 64'(exp_bytes.size()));
    for (int i = 0; i < starts.size() && i < exp_bytes.size(); i++)
      chk($sformatf("%s_byte%0d", tag, i), 64'(starts[i]), 64'(exp_bytes[i]));
  endtask
  task automatic cmp_stable(input string tag);
    for (int i = 0; i < ticks.size() && i < starts.size(); i++)
      chk($sformatf("%s_stable%0d", tag, i), 64'(ticks[i]), 64'(starts[i]));
  endtask
  task automatic push(input logic [31:0] w);
    bus.word_in    = w;
    bus.word_valid = 1'b1;
    last_push      = cyc;
    @(negedge CLK_100MHZ);
    bus.word_valid = 1'b0;
  endtask
  task automatic produce(input int base, input int cycles, output int nacc);
    logic acc;
    nacc           = 0;
    bus.word_in    = 32'(base);
    bus.word_valid = 1'b1;
    repeat (cycles) begin
      acc = bus.word_ready;
      @(negedge CLK_100MHZ);
      if (acc) begin
        add_word(32'(base + nacc));
        nacc++;
        bus.word_in = 32'(base + nacc);
      end
    end
    bus.word_valid = 1'b0;
  endtask
  task automatic tick_pulse();
    man_tick = 1'b1;
    @(negedge CLK_100MHZ);
    man_tick = 1'b0;
    @(negedge CLK_100MHZ);
    @(negedge CLK_100MHZ);
  endtask
  task automatic wait_idle(input string tag);
    int n = 0;
    while (bus.busy !== 1'b0 && n < 3000) begin
      @(negedge CLK_100MHZ);
      n++;
    end
    chk(tag, 64'(bus.busy), 64'(0));
  endtask
  task automatic drain_manual(input string tag);
    int n = 0;
    while (bus.busy !== 1'b0 && n < 300) begin
      tick_pulse();
      n++;
    end
    chk(tag, 64'(bus.busy), 64'(0));
  endtask
  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_tx_start"}, 64'(bus.tx_start), 64'(0));
    chk({tag, "_data_out"}, 64'(bus.data_out), 64'(0));
    chk({tag, "_busy"}, 64'(bus.busy), 64'(0));
    chk({tag, "_ready"}, 64'(bus.word_ready), 64'(1));
  endtask
  initial begin
    int n;
    int pushed;
    logic [31:0] w;
    bus.word_in    = '0;
    bus.word_valid = 1'b0;
    repeat (3) @(negedge CLK_100MHZ);
    chk_reset_outputs("por");
    reset = 1'b1;
    repeat (2) @(negedge CLK_100MHZ);
    // Single word with a 10-cycle transmitter: order, latency, busy fall.
    clear_logs();
    auto_en   = 1'b1;
    fixed_dly = 10;
    add_word(32'hA1B2C3D4);
    push(32'hA1B2C3D4);
    wait_idle("w1_idle");
    repeat (2) @(negedge CLK_100MHZ);
    cmp_stream("w1");
    cmp_stable("w1");
    chk("w1_latency", 64'(start_cyc.size() > 0 ? start_cyc[0] : -1), 64'(last_push + 2));
    if (tick_cyc.size() == 4) begin
      chk("w1_busy_at_tick", 64'(busy_log[tick_cyc[3]]), 64'(1));
      chk("w1_busy_after_tick", 64'(busy_log[tick_cyc[3] + 1]), 64'(0));
    end else chk("w1_tick_count", 64'(tick_cyc.size()), 64'(4));
    // Back-to-back extreme words.
    clear_logs();
    fixed_dly = 3;
    add_word(32'h0000_0000);
    add_word(32'hFFFF_FFFF);
    push(32'h0000_0000);
    push(32'hFFFF_FFFF);
    wait_idle("b2b_idle");
    repeat (2) @(negedge CLK_100MHZ);
    cmp_stream("b2b");
    cmp_stable("b2b");
    chk("b2b_gap", 64'(start_cyc.size() > 4 && tick_cyc.size() > 3 ? start_cyc[4] - tick_cyc[3] : -1), 64'(2));
    // Full FIFO: depth 4 plus one in flight, then one slot frees.
    clear_logs();
    auto_en = 1'b0;
    produce(1, 12, n);
    chk("full_accepted", 64'(n), 64'(5));
    chk("full_ready_low", 64'(bus.word_ready), 64'(0));
    chk("full_one_start", 64'(starts.size()), 64'(1));
    repeat (3) tick_pulse();
    man_tick  = 1'b1;
    auto_en   = 1'b1;
    fixed_dly = 2;
    @(negedge CLK_100MHZ);
    man_tick = 1'b0;
    produce(6, 5, n);
    chk("full_refill", 64'(n), 64'(1));
    wait_idle("full_idle");
    repeat (2) @(negedge CLK_100MHZ);
    cmp_stream("full");
    // Ticks during IDLE and during START must be ignored.
    clear_logs();
    auto_en = 1'b0;
    tick_pulse();
    chk("ign_idle_nostart", 64'(starts.size()), 64'(0));
    add_word(32'h1234_5678);
    push(32'h1234_5678);
    @(negedge CLK_100MHZ);
    chk("ign_in_start", 64'(bus.tx_start), 64'(1));
    man_tick = 1'b1;
    @(negedge CLK_100MHZ);
    man_tick = 1'b0;
    repeat (3) @(negedge CLK_100MHZ);
    chk("ign_no_extra", 64'(starts.size()), 64'(1));
    repeat (4) tick_pulse();
    wait_idle("ign_idle");
    cmp_stream("ign");
    // Push coinciding with a pop keeps the count at 2.
    clear_logs();
    for (int i = 0; i < 3; i++) begin
      add_word(32'h1000_0001 * 32'(i + 1));
      push(32'h1000_0001 * 32'(i + 1));
    end
    repeat (3) tick_pulse();
    man_tick = 1'b1;
    @(negedge CLK_100MHZ);
    man_tick       = 1'b0;
    bus.word_in    = 32'h4444_4444;
    bus.word_valid = 1'b1;
    @(negedge CLK_100MHZ);
    bus.word_valid = 1'b0;
    add_word(32'h4444_4444);
    produce(32'h5000_0000, 6, n);
    chk("pp_room_left", 64'(n), 64'(2));
    drain_manual("pp_drain");
    cmp_stream("pp");
    // Reset mid-word at idx 2 with two words queued.
    clear_logs();
    for (int i = 0; i < 3; i++) push(32'hCAFE_0000 + 32'(i));
    repeat (2) tick_pulse();
    reset = 1'b0;
    #1;
    chk_reset_outputs("rst_mid");
    @(negedge CLK_100MHZ);
    reset = 1'b1;
    clear_logs();
    auto_en = 1'b1;
    repeat (20) @(negedge CLK_100MHZ);
    chk("rst_no_start", 64'(starts.size()), 64'(0));
    chk("rst_busy", 64'(bus.busy), 64'(0));
    add_word(32'h0BAD_F00D);
    push(32'h0BAD_F00D);
    wait_idle("rst_after_idle");
    repeat (2) @(negedge CLK_100MHZ);
    cmp_stream("rst_after");
    // Randomized traffic with random transmitter delays.
    clear_logs();
    rand_dly = 1'b1;
    pushed   = 0;
    for (int i = 0; i < 30; i++) begin
      n = 0;
      while (pushed - tick_cyc.size() / 4 >= 4 && n < 2000) begin
        @(negedge CLK_100MHZ);
        n++;
      end
      chk($sformatf("rand_ready%0d", i), 64'(bus.word_ready), 64'(1));
      w = $urandom;
      add_word(w);
      push(w);
      pushed++;
      repeat ($urandom_range(0, 8)) @(negedge CLK_100MHZ);
    end
    wait_idle("rand_idle");
    repeat (2) @(negedge CLK_100MHZ);
    cmp_stream("rand");
    cmp_stable("rand");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
    $finish;
  end
endmodule

// File: doc/uart_word_tx.md
UART_WORD_TX -- requirements
Module: uart_word_tx

Interface
REQ-001 Parameter NBITS, default 8, UART byte width.
REQ-002 Parameter NBYTES, default 4, bytes per word; word width W = NBITS*NBYTES (32).
REQ-003 Parameter FIFO_DEPTH, default 4, word FIFO entries; power of two, at least 2.
REQ-004 CLK_100MHZ  input  1  single clock, all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-low; low clears all state immediately.
REQ-006 word_in  input  W  word to transmit.
REQ-007 word_valid  input  1  word_in is valid this cycle.
REQ-008 word_ready  output  1  block accepts word_in this cycle.
REQ-009 tx_done_tick  input  1  one-cycle pulse from UART transmitter: byte finished.
REQ-010 tx_start  output  1  one-cycle pulse to UART transmitter: send data_out.
REQ-011 data_out  output  NBITS  byte to UART transmitter data_in.
REQ-012 busy  output  1  high while any word is queued or in transmission.

Function
REQ-013 The FIFO SHALL store words in arrival order; a push SHALL occur on a rising edge where word_valid && word_ready.
REQ-014 word_ready SHALL equal !fifo_full, combinationally from registered FIFO count; no word SHALL be dropped or overwritten.
REQ-015 word_valid while word_ready low SHALL have no effect; the producer holds word_in.
REQ-016 The FSM SHALL have states IDLE, START and WAIT, with byte index idx in 0..NBYTES-1.
REQ-017 In IDLE with the FIFO non-empty, the block SHALL pop the head word into a W-bit shift register, set idx=0 and enter START on the same edge.
REQ-018 In START, tx_start SHALL be 1 for exactly that one cycle; on the next edge the FSM SHALL enter WAIT.
REQ-019 In WAIT, on tx_done_tick, the FSM SHALL go to IDLE if idx==NBYTES-1; otherwise it SHALL increment idx, shift the register right by NBITS and return to START.
REQ-020 Bytes SHALL be sent least-significant byte first; data_out SHALL equal shift_reg[NBITS-1:0] and SHALL stay stable from START through the end of WAIT.
REQ-021 tx_done_tick received in IDLE or START SHALL be ignored.
REQ-022 Latency: a word pushed at edge N into an empty FIFO with the FSM in IDLE SHALL produce tx_start high during the cycle after edge N+1.
REQ-023 Back-to-back words: after the final tx_done_tick of a word, with the FIFO non-empty, the next word's tx_start SHALL occur 2 cycles after the tick cycle (IDLE, then START).
REQ-024 A push and a pop on the same edge SHALL both take effect, leaving the FIFO count unchanged; pointers SHALL wrap modulo FIFO_DEPTH.
REQ-025 When the FIFO is full, a pop SHALL free a slot and word_ready SHALL rise in the following cycle.
REQ-026 The word being transmitted SHALL NOT occupy a FIFO slot, so FIFO_DEPTH+1 words can be outstanding.
REQ-027 busy SHALL equal (state != IDLE) || (FIFO count != 0).

Reset
REQ-028 While reset is low: state=IDLE, idx=0, FIFO pointers and count=0, shift register=0, tx_start=0, data_out=0, busy=0, word_ready=1.
REQ-029 Reset asserted mid-word SHALL abort the transfer and discard all queued words, with no further tx_start; after release the block SHALL behave as after power-up.

Verification
REQ-030 Push 0xA1B2C3D4 once, with tx_done_tick returned 10 cycles after each tx_start -> exactly 4 tx_start pulses with data_out D4, C3, B2, A1; busy falls 1 cycle after the 4th tick.
REQ-031 FIFO_DEPTH=4, no tx_done_tick, word_valid held high with words 1..7 -> 5 words accepted, word_ready low from then on, tx_start pulses once; after 4 ticks word_ready rises and word 6 is accepted.
REQ-032 tx_done_tick pulsed during a START cycle and while in IDLE -> idx unchanged and no extra tx_start.
REQ-033 Reset low for 1 cycle while in WAIT at idx=2 with 2 words queued -> all outputs at their reset values, and no tx_start after release until a new push.
REQ-034 FIFO holding 2 words, push on the same edge as a pop -> count stays 2 and the output byte order matches push order.
REQ-035 Words 0x00000000 and 0xFFFFFFFF sent back-to-back -> bytes 00,00,00,00,FF,FF,FF,FF, with the second word's tx_start 2 cycles after the 4th tick.
